// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant
// encoding and the latency-counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } grant_t;

  // Bits needed to hold a count of 0..lat.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants made while fetch was waiting; raises
// force_fetch once STARVE_MAX such grants have happened back to back.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data_gnt,
  input  logic fetch_gnt,
  input  logic fetch_waiting,
  output logic force_fetch
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);

  logic [SW-1:0] cnt;

  // Count data grants that bypass a waiting fetch; clear on any fairness reset point.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (fetch_gnt) begin
      cnt <= '0;
    end else if (data_gnt) begin
      if (!fetch_waiting)
        cnt <= '0;
      else if (cnt != SW'(STARVE_MAX))
        cnt <= cnt + SW'(1);
    end
  end

  assign force_fetch = (cnt == SW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port instruction/data memory arbiter. Data has strict priority
// over fetch; each access runs IDLE -> ISSUE -> WAIT with a fixed memory
// latency of MEM_LAT cycles. Define MEM_ARB_STARVE_GUARD_EN to bound how
// many consecutive data grants may bypass a waiting fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned CW = cnt_width(MEM_LAT);
  localparam int unsigned BW = DATA_W / 8;

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  if (STARVE_MAX < 1) begin : g_starve_chk
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end

  state_t          state, state_n;
  grant_t          gnt, gnt_n;
  logic            we_q, we_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            mem_en_n, mem_we_n, i_ack_n, d_ack_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, i_rdata_n, d_rdata_n;
  logic [BW-1:0]   be_n;
  logic            pick_data, pick_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic force_fetch;

  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk           (clk),
    .reset         (reset),
    .data_gnt      ((state == IDLE) && pick_data),
    .fetch_gnt     ((state == IDLE) && pick_fetch),
    .fetch_waiting (i_req),
    .force_fetch   (force_fetch)
  );

  assign pick_data = d_req && !(i_req && force_fetch);
`else
  assign pick_data = d_req;
`endif
  assign pick_fetch = i_req && !pick_data;

  // Next state plus next value of every registered output.
  // The ack is registered on the cycle the counter steps 1 -> 0 (when
  // mem_rdata is valid), so the final WAIT cycle is the one showing the ack.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    we_n      = we_q;
    cnt_n     = cnt;
    mem_en_n  = 1'b0;
    mem_we_n  = 1'b0;
    i_ack_n   = 1'b0;
    d_ack_n   = 1'b0;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    be_n      = mem_be;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    unique case (state)
      IDLE: begin
        if (pick_data) begin
          gnt_n    = GNT_DATA;
          we_n     = d_we;
          addr_n   = d_addr;
          wdata_n  = d_wdata;
          be_n     = d_we ? d_be : '1;
          mem_en_n = 1'b1;
          mem_we_n = d_we;
          state_n  = ISSUE;
        end else if (pick_fetch) begin
          gnt_n    = GNT_FETCH;
          we_n     = 1'b0;
          addr_n   = i_addr;
          wdata_n  = '0;
          be_n     = '1;
          mem_en_n = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = CW'(MEM_LAT);
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt != '0)
          cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (gnt == GNT_DATA) begin
            d_ack_n   = 1'b1;
            d_rdata_n = we_q ? '0 : mem_rdata;
          end else if (gnt == GNT_FETCH) begin
            i_ack_n   = 1'b1;
            i_rdata_n = mem_rdata;
          end
        end
        if (cnt == '0) begin
          state_n = IDLE;
          gnt_n   = GNT_NONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= GNT_NONE;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      we_q      <= we_n;
      cnt       <= cnt_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_be    <= be_n;
      i_ack     <= i_ack_n;
      d_ack     <= d_ack_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters checked every cycle against a transaction-level
// model (access timeline measured in cycles since grant).
module tb_mem_port_arbiter;

  localparam int unsigned L    = 1;
  localparam int unsigned L3   = 3;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_clr;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l3_i_req, l3_i_ack, l3_d_req, l3_d_we, l3_d_ack;
  logic [31:0] l3_i_addr, l3_i_rdata, l3_d_addr, l3_d_wdata, l3_d_rdata;
  logic [3:0]  l3_d_be, l3_mem_be;
  logic        l3_mem_en, l3_mem_we, l3_busy;
  logic [31:0] l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_req(l3_i_req), .i_addr(l3_i_addr), .i_rdata(l3_i_rdata), .i_ack(l3_i_ack),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata), .d_be(l3_d_be),
    .d_rdata(l3_d_rdata), .d_ack(l3_d_ack),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_be(l3_mem_be), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0000_0055;
      4:       return 32'h0000_0093;
      5:       return 32'h0000_0013;
      default: return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: read data appears L cycles after mem_en, noise otherwise.
  logic [31:0] mem [0:63];
  logic [31:0] rp  [0:L-1];
  assign mem_rdata = rp[L-1];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rp[0] <= mem_en ? mem[mem_addr[7:2]] : $urandom;
    for (int i = 1; i < int'(L); i++) rp[i] <= rp[i-1];
  end

  logic [31:0] rp3 [0:L3-1];
  assign l3_mem_rdata = rp3[L3-1];
  always @(posedge clk) begin
    rp3[0] <= l3_mem_en ? (l3_mem_addr ^ 32'h1234_0000) : $urandom;
    for (int i = 1; i < int'(L3); i++) rp3[i] <= rp3[i-1];
  end

  // Reference model: one access at a time, events at fixed offsets from grant.
  logic [31:0] ref_mem [0:63];
  bit          m_active, m_fetch, m_store, m_wchk, take_d;
  int          m_age, m_scnt;
  logic [31:0] m_rd, e_addr, e_wdata, e_irdata, e_drdata;
  logic [3:0]  e_be;
  logic        e_en, e_iack, e_dack;
  logic [5:0]  m_idx;

  initial begin
    m_active = 0; m_age = 0; m_scnt = 0; m_fetch = 0; m_store = 0; m_wchk = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_clr)
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      if (reset) begin
        m_active = 0; m_age = 0; m_scnt = 0; m_store = 0; m_fetch = 0; m_wchk = 1;
        e_addr = '0; e_wdata = '0; e_be = '0; e_irdata = '0; e_drdata = '0;
      end else if (!m_active) begin
        if (d_req || i_req) begin
          take_d = d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (i_req && m_scnt == int'(SMAX)) take_d = 0;
          if (take_d && i_req) m_scnt = (m_scnt < int'(SMAX)) ? m_scnt + 1 : m_scnt;
          else m_scnt = 0;
`endif
          m_active = 1;
          m_age    = 1;
          m_fetch  = !take_d;
          m_store  = take_d && d_we;
          m_wchk   = m_store;
          e_addr   = take_d ? d_addr : i_addr;
          e_be     = m_store ? d_be : 4'hF;
          e_wdata  = d_wdata;
          m_idx    = e_addr[7:2];
          if (m_store) begin
            for (int b = 0; b < 4; b++)
              if (d_be[b]) ref_mem[m_idx][8*b +: 8] = d_wdata[8*b +: 8];
            m_rd = '0;
          end else begin
            m_rd = ref_mem[m_idx];
          end
        end
      end else begin
        m_age++;
        if (m_age == int'(L) + 3) m_active = 0;
      end
      e_en   = m_active && m_age == 1;
      e_iack = m_active && m_age == int'(L) + 2 && m_fetch;
      e_dack = m_active && m_age == int'(L) + 2 && !m_fetch;
      if (e_iack) e_irdata = m_rd;
      if (e_dack) e_drdata = m_rd;
      chk("busy", busy, m_active);
      chk("mem_en", mem_en, e_en);
      if (e_en) chk("mem_we", mem_we, m_store);
      chk("i_ack", i_ack, e_iack);
      chk("d_ack", d_ack, e_dack);
      chk("i_rdata", i_rdata, e_irdata);
      chk("d_rdata", d_rdata, e_drdata);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", mem_be, e_be);
      if (m_wchk) chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit ipend, dpend, got;
  int nfetch, waitc;
  bit exp_f;

  initial begin
    reset = 1; mem_clr = 1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    l3_i_req = 0; l3_i_addr = '0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0;
    l3_d_wdata = '0; l3_d_be = '0;
    repeat (3) nxt();
    chk("rst_busy", busy, 0); chk("rst_mem_en", mem_en, 0);
    chk("rst_i_ack", i_ack, 0); chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_be", mem_be, 0);
    reset = 0; mem_clr = 0;

    // Fetch 0x10 -> 0x93.
    nxt(); i_req = 1; i_addr = 32'h10;
    nxt(); chk("f_en", mem_en, 1); chk("f_addr", mem_addr, 32'h10); chk("f_we", mem_we, 0); chk("f_busy1", busy, 1);
    nxt(); chk("f_busy2", busy, 1); chk("f_en_off", mem_en, 0);
    nxt(); chk("f_ack", i_ack, 1); chk("f_rdata", i_rdata, 32'h93); chk("f_busy3", busy, 1); i_req = 0;
    nxt(); chk("f_busy4", busy, 0); chk("f_ack_off", i_ack, 0);

    // Simultaneous requests: data wins, fetch follows.
    i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h200;
    nxt(); chk("p_en", mem_en, 1); chk("p_addr", mem_addr, 32'h200);
    nxt();
    nxt(); chk("p_dack", d_ack, 1); chk("p_drdata", d_rdata, 32'h55); chk("p_iack", i_ack, 0);
    chk("p_irdata_hold", i_rdata, 32'h93); d_req = 0;
    nxt(); chk("p_idle", busy, 0);
    nxt(); chk("p_fen", mem_en, 1); chk("p_faddr", mem_addr, 32'h14);
    nxt();
    nxt(); chk("p_fack", i_ack, 1); chk("p_frdata", i_rdata, 32'h13); chk("p_drdata_hold", d_rdata, 32'h55);
    i_req = 0;
    nxt();

    // Store 0x100, then read it back through the aliasing word.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    nxt(); chk("s_en", mem_en, 1); chk("s_we", mem_we, 1); chk("s_be", mem_be, 4'b0011);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    nxt();
    nxt(); chk("s_ack", d_ack, 1); chk("s_rdata", d_rdata, 0); d_req = 0; d_we = 0;
    nxt();
    d_req = 1; d_addr = 32'h200;
    nxt(); chk("rb_be", mem_be, 4'hF);
    nxt();
    nxt(); chk("rb_ack", d_ack, 1); chk("rb_rdata", d_rdata, 32'h0000_BEEF); d_req = 0;
    nxt();

    // Reset during WAIT abandons the fetch; a fresh one completes normally.
    i_req = 1; i_addr = 32'h10;
    nxt();
    nxt(); reset = 1; i_req = 0;
    nxt(); chk("r_busy", busy, 0); chk("r_iack", i_ack, 0); chk("r_en", mem_en, 0);
    chk("r_irdata", i_rdata, 0); reset = 0; i_req = 1;
    nxt(); chk("r_en2", mem_en, 1);
    nxt();
    nxt(); chk("r_ack2", i_ack, 1); chk("r_rdata2", i_rdata, 32'h93); i_req = 0;
    nxt();

    // MEM_LAT=3 load: ack 5 cycles after request, single mem_en.
    l3_d_req = 1; l3_d_addr = 32'h20;
    for (int c = 1; c <= 6; c++) begin
      nxt();
      chk("l3_en", l3_mem_en, c == 1);
      chk("l3_ack", l3_d_ack, c == 5);
      if (c == 5) begin
        chk("l3_rdata", l3_d_rdata, 32'h1234_0020);
        l3_d_req = 0;
      end
    end

    // Both requesters held high continuously.
    nfetch = 0;
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int g = 0; g < 20; g++) begin
      waitc = 0; got = 0;
      while (!got && waitc < 20) begin
        nxt(); waitc++;
        got = mem_en;
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL starve_wait: no grant within 20 cycles, grant %0d", g);
      end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_f = (g % 5) == 4;
`else
        exp_f = 0;
`endif
        chk("starve_gnt", mem_addr == 32'h40, exp_f);
        if (mem_addr == 32'h40) nfetch++;
      end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_nfetch", nfetch, 4);
`else
    chk("starve_nfetch", nfetch, 0);
`endif
    i_req = 0; d_req = 0;
    repeat (8) nxt();

    // Random requesters; the per-cycle model does the checking.
    ipend = 0; dpend = 0;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (reset) reset = 0;
      if (i_ack) ipend = 0;
      if (d_ack) dpend = 0;
      if ($urandom_range(0, 249) == 0) begin
        reset = 1; ipend = 0; dpend = 0;
      end else begin
        if (!ipend && $urandom_range(0, 2) == 0) begin
          ipend = 1; i_addr = $urandom;
        end else if (ipend && $urandom_range(0, 3) == 0) begin
          i_addr = $urandom;
        end
        if (!dpend && $urandom_range(0, 2) == 0) begin
          dpend = 1; d_we = 1'($urandom); d_addr = $urandom;
          d_wdata = $urandom; d_be = 4'($urandom);
        end else if (dpend && $urandom_range(0, 3) == 0) begin
          d_addr = $urandom; d_wdata = $urandom;
        end
      end
      i_req = ipend; d_req = dpend;
    end
    i_req = 0; d_req = 0;
    repeat (8) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
